// File: rtl/reg_scoreboard_if.sv
// Issue / writeback / squash bundle between decode, the pipeline and the register scoreboard.
// Decode and the pipeline side own the master modport; the scoreboard owns the slave modport.
interface reg_scoreboard_if #(
    parameter int MAX_INFLIGHT = 6
) ();
    localparam int ICW = $clog2(MAX_INFLIGHT + 1);

    logic           issue_valid;
    logic [4:0]     issue_rs1;
    logic [4:0]     issue_rs2;
    logic           issue_use_rs1;
    logic           issue_use_rs2;
    logic [4:0]     issue_rd;
    logic           issue_wr;
    logic           issue_ready;

    logic           retire_valid;
    logic [4:0]     retire_rd;
    logic           kill_valid;
    logic [4:0]     kill_rd;

    logic [31:0]    busy_mask;
    logic [ICW-1:0] inflight_count;
    logic           err_underflow;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
        output issue_rd, issue_wr, retire_valid, retire_rd, kill_valid, kill_rd,
        input  issue_ready, busy_mask, inflight_count, err_underflow
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
        input  issue_rd, issue_wr, retire_valid, retire_rd, kill_valid, kill_rd,
        output issue_ready, busy_mask, inflight_count, err_underflow
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register in-flight write counters gating issue into register read; counts update one edge after
// issue/retire/kill, and issue_ready is a pure function of registered counts and the issue_* fields.
module reg_scoreboard #(
    parameter int MAX_PER_REG  = 3,
    parameter int MAX_INFLIGHT = 6
) (
    input  logic          clk,
    input  logic          rst,
    reg_scoreboard_if.slave sb
);
    localparam int CW  = $clog2(MAX_PER_REG + 1);
    localparam int ICW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_PER_REG);
    localparam logic [ICW-1:0] INF_MAX = ICW'(MAX_INFLIGHT);

    logic [CW-1:0]  counts_q [32];
    logic [CW-1:0]  counts_d [32];
    logic [ICW-1:0] inflight_q;
    logic [ICW-1:0] inflight_d;
    logic           err_q;
    logic           err_d;

    logic           rs1_hazard;
    logic           rs2_hazard;
    logic           eff_wr;
    logic           wr_room;
    logic           ready;
    logic           issue_inc;
    logic           ret_req;
    logic           kill_req;
    logic           same_reg;
    logic           apply_ret;
    logic           apply_kill;
    logic           kill_avail;
    logic [31:0]    busy;

    assign rs1_hazard = sb.issue_use_rs1 && (sb.issue_rs1 != 5'd0) && (counts_q[sb.issue_rs1] != '0);
    assign rs2_hazard = sb.issue_use_rs2 && (sb.issue_rs2 != 5'd0) && (counts_q[sb.issue_rs2] != '0);
    assign eff_wr     = sb.issue_wr && (sb.issue_rd != 5'd0);
    assign wr_room    = (counts_q[sb.issue_rd] < CNT_MAX) && (inflight_q < INF_MAX);

    // Deliberately independent of issue_valid so decode can use it in its own stall logic.
    assign ready      = !rs1_hazard && !rs2_hazard && (!eff_wr || wr_room);
    assign issue_inc  = sb.issue_valid && ready && eff_wr;

    assign ret_req    = sb.retire_valid && (sb.retire_rd != 5'd0);
    assign kill_req   = sb.kill_valid && (sb.kill_rd != 5'd0);
    assign same_reg   = (sb.retire_rd == sb.kill_rd);
    assign apply_ret  = ret_req && (counts_q[sb.retire_rd] != '0);

    // When retire already consumed one unit of the same register, kill needs a second one.
    assign kill_avail = (apply_ret && same_reg) ? (counts_q[sb.kill_rd] > CW'(1))
                                                : (counts_q[sb.kill_rd] != '0);
    assign apply_kill = kill_req && kill_avail;

    always_comb begin
        counts_d[0] = '0;
        for (int r = 1; r < 32; r++) begin
            counts_d[r] = counts_q[r]
                        + CW'(issue_inc  && (sb.issue_rd  == 5'(r)))
                        - CW'(apply_ret  && (sb.retire_rd == 5'(r)))
                        - CW'(apply_kill && (sb.kill_rd   == 5'(r)));
        end
    end

    assign inflight_d = inflight_q + ICW'(issue_inc) - ICW'(apply_ret) - ICW'(apply_kill);
    assign err_d      = err_q || (ret_req && !apply_ret) || (kill_req && !apply_kill);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                counts_q[r] <= '0;
            end
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                counts_q[r] <= counts_d[r];
            end
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        busy = '0;
        for (int r = 0; r < 32; r++) begin
            busy[r] = (counts_q[r] != '0);
        end
    end

    assign sb.issue_ready    = ready;
    assign sb.busy_mask      = busy;
    assign sb.inflight_count = inflight_q;
    assign sb.err_underflow  = err_q;
endmodule
